// File: rtl/iir_pkg.sv
// Shared types and helpers for the stereo biquad cascade.
//   state_t   : sequencer states (IDLE, MAC, WB, DONE)
//   tap_e     : coefficient tap order within one stage (b0,b1,b2,a1,a2)
//   TAPS      : coefficients per biquad stage
//   sat_round : round-half-up by 'frac' bits, then clamp to a signed
//               'data_w'-bit range; caller truncates to its sample width
package iir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;
  typedef enum logic [2:0] {B0, B1, B2, A1, A2} tap_e;

  localparam int TAPS = 5;

  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int frac,
                                                   input int data_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    // Adding half an LSB and then flooring with >>> rounds ties upward.
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/iir_mac_acc.sv
// Signed multiply-accumulate with a registered accumulator.
//   clk, reset : clock, async active-low reset (clears acc)
//   clr        : start a new sum (previous acc is discarded)
//   en         : perform one product-add/sub this cycle
//   sub        : subtract the product instead of adding it
//   a, b       : signed operands (sample, coefficient)
//   acc        : signed ACC_W accumulator
module iir_mac_acc #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    sub,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [A_W+B_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   base;

  assign prod     = a * b;
  assign prod_ext = ACC_W'(prod);   // sign-extends: prod is signed
  assign base     = clr ? '0 : acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= sub ? (base - prod_ext) : (base + prod_ext);
    end
  end

endmodule

// File: rtl/iir_biquad_cascade_stereo.sv
// Stereo cascade of N_STAGES Direct-Form-I biquads on one shared MAC.
// Each l_r_clk edge (after a 2-FF synchronizer) starts a full cascade run
// for the channel given by the new level (0 = left, 1 = right).
//   clk, reset   : clock, async active-low reset
//   l_r_clk      : I2S word select (asynchronous)
//   sample_in    : signed sample for the channel just selected
//   coef_we      : write coef_wdata into shadow[coef_addr] (stage*5 + tap)
//   coef_commit  : copy shadow bank to active bank (deferred while busy)
//   out_left/out_right : last filtered sample per channel
//   out_valid    : one-cycle strobe with no back-pressure; out_chan names
//                  the channel whose output register changed this cycle
//   busy         : sequencer not idle
//   overrun      : sticky, an edge arrived while busy (sample dropped)
module iir_biquad_cascade_stereo
  import iir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int N_STAGES  = 4,
  parameter int ACC_W     = 40
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          l_r_clk,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          coef_we,
  input  logic [$clog2(5*N_STAGES)-1:0] coef_addr,
  input  logic [COEF_W-1:0]             coef_wdata,
  input  logic                          coef_commit,
  output logic [DATA_W-1:0]             out_left,
  output logic [DATA_W-1:0]             out_right,
  output logic                          out_valid,
  output logic                          out_chan,
  output logic                          busy,
  output logic                          overrun
);

  localparam int NC = TAPS * N_STAGES;
  localparam int AW = $clog2(NC);
  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  logic                     sync_d1, sync_d2, lr_edge;
  state_t                   state;
  tap_e                     tap;
  logic [SW-1:0]            stage;
  logic                     chan;
  logic signed [DATA_W-1:0] x_in;            // input of the current stage
  // History per channel/stage: [0]=x1 [1]=x2 [2]=y1 [3]=y2
  logic signed [DATA_W-1:0] hist [2][N_STAGES][4];
  logic signed [COEF_W-1:0] shadow [NC];
  logic signed [COEF_W-1:0] active [NC];
  logic                     commit_pending;

  logic [AW-1:0]            coef_idx;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [COEF_W-1:0] mac_b;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] r_sat;

  assign lr_edge  = sync_d1 ^ sync_d2;
  assign busy     = (state != IDLE);
  assign coef_idx = AW'(int'(stage) * TAPS + int'(tap));
  assign mac_b    = active[coef_idx];
  assign r_sat    = DATA_W'(sat_round(64'(acc), COEF_FRAC, DATA_W));

  always_comb begin
    mac_a = x_in;
    case (tap)
      B1:      mac_a = hist[chan][stage][0];
      B2:      mac_a = hist[chan][stage][1];
      A1:      mac_a = hist[chan][stage][2];
      A2:      mac_a = hist[chan][stage][3];
      default: mac_a = x_in;
    endcase
  end

  // a1/a2 are stored as written; the feedback sign is applied by subtracting.
  iir_mac_acc #(.A_W(DATA_W), .B_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (tap == B0),
    .en    (state == MAC),
    .sub   ((tap == A1) || (tap == A2)),
    .a     (mac_a),
    .b     (mac_b),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_d1        <= 1'b0;
      sync_d2        <= 1'b0;
      state          <= IDLE;
      tap            <= B0;
      stage          <= '0;
      chan           <= 1'b0;
      x_in           <= '0;
      commit_pending <= 1'b0;
      out_left       <= '0;
      out_right      <= '0;
      out_valid      <= 1'b0;
      out_chan       <= 1'b0;
      overrun        <= 1'b0;
      for (int c = 0; c < 2; c++)
        for (int s = 0; s < N_STAGES; s++)
          for (int k = 0; k < 4; k++)
            hist[c][s][k] <= '0;
      for (int i = 0; i < NC; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      sync_d1   <= l_r_clk;
      sync_d2   <= sync_d1;
      out_valid <= 1'b0;

      if (coef_we && (int'(coef_addr) < NC))
        shadow[coef_addr] <= coef_wdata;

      // While busy, edges are dropped and commits are parked until IDLE.
      if (state != IDLE) begin
        if (lr_edge)     overrun        <= 1'b1;
        if (coef_commit) commit_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          // Commit lands on the same edge that latches a new sample, so the
          // MAC for that sample already sees the new bank.
          if (coef_commit || commit_pending) begin
            for (int i = 0; i < NC; i++) active[i] <= shadow[i];
            commit_pending <= 1'b0;
          end
          if (lr_edge) begin
            x_in  <= sample_in;
            chan  <= sync_d1;
            stage <= '0;
            tap   <= B0;
            state <= MAC;
          end
        end
        MAC: begin
          if (tap == A2) state <= WB;
          else           tap   <= tap_e'(tap + 3'd1);
        end
        WB: begin
          hist[chan][stage][1] <= hist[chan][stage][0];
          hist[chan][stage][0] <= x_in;
          hist[chan][stage][3] <= hist[chan][stage][2];
          hist[chan][stage][2] <= r_sat;
          if (stage == SW'(N_STAGES - 1)) begin
            // Outputs are registered here so they are visible during DONE.
            if (chan) out_right <= r_sat;
            else      out_left  <= r_sat;
            out_valid <= 1'b1;
            out_chan  <= chan;
            state     <= DONE;
          end else begin
            x_in  <= r_sat;
            stage <= stage + SW'(1);
            tap   <= B0;
            state <= MAC;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade_stereo.sv
// Bench for iir_biquad_cascade_stereo: hand-written corner sequences,
// a table of single-sample vectors and randomized traffic scored against
// a difference-equation reference model.
module tb_iir_biquad_cascade_stereo;

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 14;
  localparam int N_STAGES  = 4;
  localparam int ACC_W     = 40;
  localparam int NC        = 5 * N_STAGES;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        l_r_clk = 1'b0;
  logic [15:0] sample_in = '0;
  logic        coef_we = 1'b0;
  logic [4:0]  coef_addr = '0;
  logic [15:0] coef_wdata = '0;
  logic        coef_commit = 1'b0;
  logic [15:0] out_left, out_right;
  logic        out_valid, out_chan, busy, overrun;

  always #5 clk = ~clk;

  iir_biquad_cascade_stereo #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC),
    .N_STAGES(N_STAGES), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset), .l_r_clk(l_r_clk), .sample_in(sample_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .out_left(out_left), .out_right(out_right),
    .out_valid(out_valid), .out_chan(out_chan), .busy(busy), .overrun(overrun)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];

  // Reference model: coefficient banks and y/x memories as plain integers.
  longint m_sh [NC];
  longint m_act[NC];
  longint m_hist[2][N_STAGES][4];   // x[n-1], x[n-2], y[n-1], y[n-2]

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NC; i++) begin
      m_sh[i]  = 0;
      m_act[i] = 0;
    end
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < N_STAGES; s++)
        for (int k = 0; k < 4; k++)
          m_hist[c][s][k] = 0;
  endfunction

  // y[n] = b0 x[n] + b1 x[n-1] + b2 x[n-2] - a1 y[n-1] - a2 y[n-2],
  // scaled by 2^-COEF_FRAC, rounded half up, clamped to 16 bits.
  function automatic logic [15:0] model_run(input int ch, input logic [15:0] xin);
    longint x, acc, r;
    x = longint'($signed(xin));
    for (int s = 0; s < N_STAGES; s++) begin
      acc = m_act[s*5] * x + m_act[s*5+1] * m_hist[ch][s][0]
          + m_act[s*5+2] * m_hist[ch][s][1]
          - m_act[s*5+3] * m_hist[ch][s][2] - m_act[s*5+4] * m_hist[ch][s][3];
      r = (acc + (longint'(1) << (COEF_FRAC - 1))) >>> COEF_FRAC;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      m_hist[ch][s][1] = m_hist[ch][s][0];
      m_hist[ch][s][0] = x;
      m_hist[ch][s][3] = m_hist[ch][s][2];
      m_hist[ch][s][2] = r;
      x = r;
    end
    return x[15:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_coef(input int addr, input logic [15:0] v);
    coef_addr  = 5'(addr);
    coef_wdata = v;
    coef_we    = 1'b1;
    tick();
    coef_we = 1'b0;
    if (addr < NC) m_sh[addr] = longint'($signed(v));
  endtask

  // Only called while the DUT is idle, so the copy is immediate.
  task automatic commit_now();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    for (int i = 0; i < NC; i++) m_act[i] = m_sh[i];
  endtask

  // b0 of stage 0 = first, b0 of later stages = rest, all other taps 0.
  task automatic load_b0(input logic [15:0] first, input logic [15:0] rest);
    for (int i = 0; i < NC; i++)
      write_coef(i, (i == 0) ? first : ((i % 5 == 0) ? rest : 16'h0000));
    commit_now();
  endtask

  // Toggle word select (new level = channel), wait for the result and
  // score it against the model; returns the channel's output register.
  task automatic send(input logic [15:0] val, output logic [15:0] got);
    int          lat;
    logic        ch;
    logic [15:0] e;
    sample_in = val;
    l_r_clk   = ~l_r_clk;
    ch        = l_r_clk;
    exp_q.push_back(model_run(int'(ch), val));
    lat = -1;
    got = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    // Edge seen one cycle after the toggle (cycle E), result at E+25.
    check("latency", lat - 1, 25);
    e = exp_q.pop_front();
    if (lat > 0) begin
      got = ch ? out_right : out_left;
      check("out_chan", out_chan, ch);
      check("model", got, e);
    end
    tick();
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (out_valid) n++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] b0_first;
    logic [15:0] b0_rest;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] got;
    logic [15:0] iso_exp[6];
    int          n, lat;
    logic        ch5;

    vecs[0] = '{16'h4000, 16'h4000, 16'h1234, 16'h1234};  // passthrough
    vecs[1] = '{16'h4000, 16'h4000, 16'hEDCC, 16'hEDCC};
    vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h7000, 16'h7FFF};  // positive clamp
    vecs[3] = '{16'h7FFF, 16'h7FFF, 16'h9000, 16'h8000};  // negative clamp
    vecs[4] = '{16'h2000, 16'h4000, 16'h0003, 16'h0002};  // 1.5 -> 2
    vecs[5] = '{16'h2000, 16'h4000, 16'hFFFD, 16'hFFFF};  // -1.5 -> -1
    vecs[6] = '{16'h2000, 16'h4000, 16'h0001, 16'h0001};  // 0.5 -> 1
    vecs[7] = '{16'h2000, 16'h4000, 16'hFFFF, 16'h0000};  // -0.5 -> 0

    model_clear();

    // ---- reset ----
    repeat (3) tick();
    check("rst_out_left", out_left, 0);
    check("rst_out_right", out_right, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick();
    check("rst_out_chan", out_chan, 0);
    check("rst_overrun", overrun, 0);

    // ---- stereo isolation: stage0 integrator (a1 = -1.0) ----
    for (int i = 0; i < NC; i++) begin
      if (i % 5 == 0)  write_coef(i, 16'h4000);
      else if (i == 3) write_coef(i, 16'hC000);
      else             write_coef(i, 16'h0000);
    end
    commit_now();
    // First toggle goes to right: R0, L impulse, R0, L0, R0, L0
    iso_exp = '{16'h0000, 16'h1000, 16'h0000, 16'h1000, 16'h0000, 16'h1000};
    for (int i = 0; i < 6; i++) begin
      send((i == 1) ? 16'h1000 : 16'h0000, got);
      check("isolation", got, iso_exp[i]);
    end

    // ---- table-driven single samples ----
    for (int i = 0; i < 8; i++) begin
      load_b0(vecs[i].b0_first, vecs[i].b0_rest);
      send(vecs[i].din, got);
      check("table_vec", got, vecs[i].exp);
    end

    // ---- overrun and deferred commit ----
    load_b0(16'h4000, 16'h4000);
    write_coef(0, 16'h2000);          // shadow only
    sample_in = 16'h0100;
    l_r_clk   = ~l_r_clk;
    ch5       = l_r_clk;
    exp_q.push_back(model_run(int'(ch5), 16'h0100));
    lat = -1;
    got = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 4) coef_commit = 1'b1;             // cycle E+3
      if (k == 5) begin
        coef_commit = 1'b0;
        sample_in   = 16'h7777;
        l_r_clk     = ~l_r_clk;                   // edge lands in E+5
      end
      if (out_valid) begin
        lat = k;
        got = ch5 ? out_right : out_left;
        break;
      end
    end
    check("ovr_latency", lat - 1, 25);
    check("ovr_old_coef", got, 16'h0100);
    check("ovr_model", got, exp_q.pop_front());
    for (int i = 0; i < NC; i++) m_act[i] = m_sh[i];
    tick();
    count_valid(40, n);
    check("ovr_dropped", n, 0);
    check("ovr_sticky", overrun, 1);
    send(16'h0100, got);
    check("deferred_commit", got, 16'h0080);

    // ---- randomized coefficients and samples ----
    for (int i = 0; i < NC; i++) begin
      if (i % 5 < 3) write_coef(i, 16'($urandom_range(0, 24576) - 32'd12288));
      else           write_coef(i, 16'($urandom_range(0, 8192) - 32'd4096));
    end
    write_coef(NC + int'($urandom_range(0, 31 - NC)), 16'h7FFF);  // ignored
    commit_now();
    for (int i = 0; i < 24; i++) send(16'($urandom_range(0, 65535)), got);

    // ---- asynchronous reset mid-sample ----
    load_b0(16'h4000, 16'h4000);
    send(16'h4321, got);
    sample_in = 16'h1111;
    l_r_clk   = ~l_r_clk;
    repeat (11) tick();               // now in cycle E+10
    #1;
    reset   = 1'b0;
    l_r_clk = 1'b0;
    #1;
    check("arst_out_left", out_left, 0);
    check("arst_out_right", out_right, 0);
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_overrun", overrun, 0);
    model_clear();
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    count_valid(40, n);
    check("arst_no_valid", n, 0);
    load_b0(16'h4000, 16'h4000);
    send(16'h2468, got);
    check("arst_passthru", got, 16'h2468);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
